wb_periph_ic_1xn: RTL

Parametrised 1-master to N-slave Wishbone register interconnect for peripheral subsystems. It generalises the fixed three-slave decoder and adds four things: a per-slave base/limit table, a registered (pipelined) request stage, a decode-miss ERR response, and a bus-timeout watchdog with error capture. It sits between the subsystem address-truncation adapter and the peripheral register ports (DMA, UART, PIC, …).

---
 rtl/wb_periph_ic_1xn_if.sv | 28 ++
 rtl/wb_periph_ic_1xn.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_periph_ic_1xn_if.sv
// Wishbone classic bus bundle used on the master side of the peripheral
// interconnect. Widths follow the interconnect's address/data parameters.
interface wb_if #(
   parameter int WB_ADDR_WIDTH = 12,
   parameter int WB_DATA_WIDTH = 32
);
   logic [WB_ADDR_WIDTH-1:0]   ADR;
   logic [WB_DATA_WIDTH-1:0]   DAT_W;
   logic [WB_DATA_WIDTH-1:0]   DAT_R;
   logic [WB_DATA_WIDTH/8-1:0] SEL;
   logic                       WE;
   logic                       CYC;
   logic                       STB;
   logic                       ACK;
   logic                       ERR;

   // Seen from the interconnect: requests come in, responses go out.
   modport slave (
      input  ADR, DAT_W, SEL, WE, CYC, STB,
      output DAT_R, ACK, ERR
   );

   // Seen from an upstream master.
   modport master (
      output ADR, DAT_W, SEL, WE, CYC, STB,
      input  DAT_R, ACK, ERR
   );
endinterface

// File: rtl/wb_periph_ic_1xn.sv
// 1-master to N-slave Wishbone register interconnect.
// The request is registered once and then presented to a single slave chosen
// by a base/limit table (lowest index wins on overlap). Unmapped addresses
// get an ERR response, a watchdog turns a stuck slave into a timeout ERR, and
// the cause and address of the most recent error are held for software.
module wb_periph_ic_1xn #(
   parameter int WB_ADDR_WIDTH  = 12,
   parameter int WB_DATA_WIDTH  = 32,
   parameter int N_SLAVES       = 4,
   parameter logic [N_SLAVES*WB_ADDR_WIDTH-1:0] SLAVE_ADDR_BASE  = '0,
   parameter logic [N_SLAVES*WB_ADDR_WIDTH-1:0] SLAVE_ADDR_LIMIT = '0,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                                clk,
   input  logic                                rst,
   wb_if.slave                                 m,
   output logic [WB_ADDR_WIDTH-1:0]            s_adr,
   output logic [WB_DATA_WIDTH-1:0]            s_dat_w,
   output logic [WB_DATA_WIDTH/8-1:0]          s_sel,
   output logic                                s_we,
   output logic [N_SLAVES-1:0]                 s_cyc,
   output logic [N_SLAVES-1:0]                 s_stb,
   input  logic [N_SLAVES*WB_DATA_WIDTH-1:0]   s_dat_r,
   input  logic [N_SLAVES-1:0]                 s_ack,
   input  logic [N_SLAVES-1:0]                 s_err,
   output logic                                err_o,
   output logic [1:0]                          err_code_o,
   output logic [WB_ADDR_WIDTH-1:0]            err_addr_o
);

   localparam int SEL_W = WB_DATA_WIDTH / 8;
   localparam int IDX_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
   // Counter only needs to reach TIMEOUT_CYCLES-1; the terminal cycle itself
   // is the one in which the timeout is taken.
   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] TO_LAST =
      CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
   localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

   localparam logic [1:0] ERR_NONE    = 2'd0;
   localparam logic [1:0] ERR_DECODE  = 2'd1;
   localparam logic [1:0] ERR_TIMEOUT = 2'd2;
   localparam logic [1:0] ERR_SLAVE   = 2'd3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t                     state_q;
   logic [WB_ADDR_WIDTH-1:0]   adr_q;
   logic [WB_DATA_WIDTH-1:0]   dat_w_q;
   logic [SEL_W-1:0]           sel_q;
   logic                       we_q;
   logic [IDX_W-1:0]           idx_q;
   logic [CNT_W-1:0]           cnt_q;
   logic [N_SLAVES-1:0]        s_cyc_q;
   logic                       ack_q;
   logic                       err_q;
   logic [WB_DATA_WIDTH-1:0]   dat_r_q;
   logic                       err_o_q;
   logic [1:0]                 err_code_q;
   logic [WB_ADDR_WIDTH-1:0]   err_addr_q;

   logic                       hit_d;
   logic [IDX_W-1:0]           idx_d;
   logic                       sel_ack;
   logic                       sel_err;
   logic [WB_DATA_WIDTH-1:0]   sel_dat;
   logic                       to_hit;

   // One-hot strobe vector for the chosen slave.
   function automatic logic [N_SLAVES-1:0] onehot(input logic [IDX_W-1:0] i);
      logic [N_SLAVES-1:0] v;
      v = '0;
      for (int k = 0; k < N_SLAVES; k++) begin
         if (IDX_W'(k) == i) v[k] = 1'b1;
      end
      return v;
   endfunction

   // Address decode: scan from the top so the lowest matching index is kept.
   always_comb begin
      hit_d = 1'b0;
      idx_d = '0;
      for (int i = N_SLAVES - 1; i >= 0; i--) begin
         if ((m.ADR >= SLAVE_ADDR_BASE[i*WB_ADDR_WIDTH +: WB_ADDR_WIDTH]) &&
             (m.ADR <= SLAVE_ADDR_LIMIT[i*WB_ADDR_WIDTH +: WB_ADDR_WIDTH])) begin
            hit_d = 1'b1;
            idx_d = IDX_W'(i);
         end
      end
   end

   // Response of the selected slave only; other slaves' strobes are ignored.
   always_comb begin
      sel_ack = 1'b0;
      sel_err = 1'b0;
      sel_dat = '0;
      for (int i = 0; i < N_SLAVES; i++) begin
         if (IDX_W'(i) == idx_q) begin
            sel_ack = s_ack[i];
            sel_err = s_err[i];
            sel_dat = s_dat_r[i*WB_DATA_WIDTH +: WB_DATA_WIDTH];
         end
      end
      to_hit = TO_EN && (cnt_q == TO_LAST);
   end

   // Transfer FSM: request capture, slave wait with watchdog, one-cycle response.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         adr_q      <= '0;
         dat_w_q    <= '0;
         sel_q      <= '0;
         we_q       <= 1'b0;
         idx_q      <= '0;
         cnt_q      <= '0;
         s_cyc_q    <= '0;
         ack_q      <= 1'b0;
         err_q      <= 1'b0;
         dat_r_q    <= '0;
         err_o_q    <= 1'b0;
         err_code_q <= ERR_NONE;
         err_addr_q <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (m.CYC && m.STB) begin
                  adr_q   <= m.ADR;
                  dat_w_q <= m.DAT_W;
                  sel_q   <= m.SEL;
                  we_q    <= m.WE;
                  idx_q   <= idx_d;
                  cnt_q   <= '0;
                  if (hit_d) begin
                     s_cyc_q <= onehot(idx_d);
                     state_q <= BUSY;
                  end else begin
                     err_q      <= 1'b1;
                     err_o_q    <= 1'b1;
                     err_code_q <= ERR_DECODE;
                     err_addr_q <= m.ADR;
                     state_q    <= RESP;
                  end
               end
            end
            BUSY: begin
               if (!m.CYC) begin
                  // Master gave up: release the slave silently.
                  s_cyc_q <= '0;
                  state_q <= IDLE;
               end else if (sel_err) begin
                  // ERR takes priority over a simultaneous ACK.
                  s_cyc_q    <= '0;
                  err_q      <= 1'b1;
                  err_o_q    <= 1'b1;
                  err_code_q <= ERR_SLAVE;
                  err_addr_q <= adr_q;
                  state_q    <= RESP;
               end else if (sel_ack) begin
                  s_cyc_q <= '0;
                  ack_q   <= 1'b1;
                  if (!we_q) dat_r_q <= sel_dat;
                  state_q <= RESP;
               end else if (to_hit) begin
                  s_cyc_q    <= '0;
                  err_q      <= 1'b1;
                  err_o_q    <= 1'b1;
                  err_code_q <= ERR_TIMEOUT;
                  err_addr_q <= adr_q;
                  state_q    <= RESP;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            RESP: begin
               // Response lasts one cycle; no new request is taken here.
               ack_q   <= 1'b0;
               err_q   <= 1'b0;
               err_o_q <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               s_cyc_q <= '0;
               ack_q   <= 1'b0;
               err_q   <= 1'b0;
               err_o_q <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign s_adr      = adr_q;
   assign s_dat_w    = dat_w_q;
   assign s_sel      = sel_q;
   assign s_we       = we_q;
   assign s_cyc      = s_cyc_q;
   assign s_stb      = s_cyc_q;
   assign m.ACK      = ack_q;
   assign m.ERR      = err_q;
   assign m.DAT_R    = dat_r_q;
   assign err_o      = err_o_q;
   assign err_code_o = err_code_q;
   assign err_addr_o = err_addr_q;

endmodule
